// File: rtl/segment_transition_ctl.sv
// Segment sequencer: tracks active segment, sample index, repetition count and STOP,
// and switches segments on SYNC_IDX / SYS_TIME / GPIO / IMMEDIATE / EXT transition modes.
module segment_transition_ctl #(
  parameter  int NumSegment = 4,
  parameter  int IdxWidth   = 16,
  parameter  int RepWidth   = 16,
  localparam int SegWidth   = $clog2(NumSegment)
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           UPDATE,
  input  logic [63:0]                    SYS_TIME,
  input  logic [3:0]                     GPIO_IN,
  input  logic                           REQ_VALID,
  input  logic [SegWidth-1:0]            REQ_SEGMENT,
  input  logic [7:0]                     TRANSITION_MODE,
  input  logic [63:0]                    TRANSITION_VALUE,
  input  logic [NumSegment*IdxWidth-1:0] CYCLE,
  input  logic [NumSegment*RepWidth-1:0] REP,
  output logic [SegWidth-1:0]            SEGMENT,
  output logic [IdxWidth-1:0]            IDX,
  output logic                           STOP,
  output logic                           PENDING,
  output logic                           TRANSITION_PULSE
);

  localparam logic [7:0] MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0] MODE_GPIO      = 8'h02;
  localparam logic [7:0] MODE_EXT       = 8'hF0;
  localparam logic [7:0] MODE_IMMEDIATE = 8'hFF;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state;
  logic [RepWidth-1:0]  rep_cnt;
  logic [SegWidth-1:0]  tgt_q;
  logic [7:0]           mode_q;
  logic [63:0]          val_q;
  logic                 gpio_seen;
  logic                 ext_mode;

  logic [IdxWidth-1:0]  cyc_cur;
  logic [RepWidth-1:0]  rep_cur;
  logic                 rep_inf, wrap, gpio_hit, wait_sw, auto_sw, do_sw, req_known;
  logic [SegWidth-1:0]  seg_next, sw_tgt;

  assign cyc_cur  = CYCLE[int'(SEGMENT)*IdxWidth +: IdxWidth];
  assign rep_cur  = REP[int'(SEGMENT)*RepWidth +: RepWidth];
  assign rep_inf  = &rep_cur;
  // >= rather than == so a CYCLE shrink below the live index still wraps
  assign wrap     = UPDATE && (IDX >= cyc_cur);
  assign gpio_hit = GPIO_IN[val_q[1:0]];
  assign seg_next = (SEGMENT == SegWidth'(NumSegment-1)) ? '0 : SEGMENT + 1'b1;

  always_comb begin
    wait_sw = 1'b0;
    if (state == WAIT) begin
      case (mode_q)
        MODE_SYNC_IDX:  wait_sw = wrap || (UPDATE && STOP);
        MODE_SYS_TIME:  wait_sw = UPDATE && (SYS_TIME >= val_q);
        MODE_GPIO:      wait_sw = UPDATE && (gpio_seen || gpio_hit);
        MODE_IMMEDIATE: wait_sw = UPDATE;
        default:        wait_sw = 1'b0;
      endcase
    end
  end

  // EXT auto-advance replaces STOP when a finite segment runs out of repetitions
  assign auto_sw   = ext_mode && !STOP && wrap && !rep_inf && (rep_cnt == rep_cur);
  assign do_sw     = wait_sw || auto_sw;
  assign sw_tgt    = wait_sw ? tgt_q : seg_next;
  assign req_known = (TRANSITION_MODE == MODE_SYNC_IDX) || (TRANSITION_MODE == MODE_SYS_TIME) ||
                     (TRANSITION_MODE == MODE_GPIO)     || (TRANSITION_MODE == MODE_EXT)      ||
                     (TRANSITION_MODE == MODE_IMMEDIATE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state            <= IDLE;
      SEGMENT          <= '0;
      IDX              <= '0;
      STOP             <= 1'b0;
      PENDING          <= 1'b0;
      TRANSITION_PULSE <= 1'b0;
      rep_cnt          <= '0;
      tgt_q            <= '0;
      mode_q           <= '0;
      val_q            <= '0;
      gpio_seen        <= 1'b0;
      ext_mode         <= 1'b0;
    end else begin
      TRANSITION_PULSE <= 1'b0;
      if (state == WAIT && gpio_hit) gpio_seen <= 1'b1;

      if (do_sw) begin
        SEGMENT          <= sw_tgt;
        IDX              <= '0;
        rep_cnt          <= '0;
        STOP             <= 1'b0;
        TRANSITION_PULSE <= 1'b1;
        PENDING          <= 1'b0;
        state            <= IDLE;
        gpio_seen        <= 1'b0;
      end else if (!STOP && UPDATE) begin
        if (!wrap)                   IDX <= IDX + 1'b1;
        else if (rep_inf)            IDX <= '0;
        else if (rep_cnt == rep_cur) STOP <= 1'b1;
        else begin
          rep_cnt <= rep_cnt + 1'b1;
          IDX     <= '0;
        end
      end

      // A request arriving with a switch is latched after the switch consumed the old one
      if (REQ_VALID && req_known) begin
        gpio_seen <= 1'b0;
        if (TRANSITION_MODE == MODE_EXT) begin
          ext_mode <= 1'b1;
          state    <= IDLE;
          PENDING  <= 1'b0;
        end else begin
          ext_mode <= 1'b0;
          tgt_q    <= REQ_SEGMENT;
          mode_q   <= TRANSITION_MODE;
          val_q    <= TRANSITION_VALUE;
          state    <= WAIT;
          PENDING  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Bench for segment_transition_ctl: directed scenarios plus random traffic against a
// cycle-level behavioural model of the segment sequencing rules.
module tb_segment_transition_ctl;
  localparam int NS = 4;
  localparam int IW = 16;
  localparam int RW = 16;
  localparam int INF = 65535;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          UPDATE = 1'b0;
  logic [63:0]   SYS_TIME = '0;
  logic [3:0]    GPIO_IN = '0;
  logic          REQ_VALID = 1'b0;
  logic [1:0]    REQ_SEGMENT = '0;
  logic [7:0]    TRANSITION_MODE = '0;
  logic [63:0]   TRANSITION_VALUE = '0;
  logic [NS*IW-1:0] CYCLE = '0;
  logic [NS*RW-1:0] REP = '0;
  logic [1:0]    SEGMENT;
  logic [IW-1:0] IDX;
  logic          STOP, PENDING, TRANSITION_PULSE;

  segment_transition_ctl #(.NumSegment(NS), .IdxWidth(IW), .RepWidth(RW)) dut (
    .CLK(CLK), .RST_N(RST_N), .UPDATE(UPDATE), .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN),
    .REQ_VALID(REQ_VALID), .REQ_SEGMENT(REQ_SEGMENT), .TRANSITION_MODE(TRANSITION_MODE),
    .TRANSITION_VALUE(TRANSITION_VALUE), .CYCLE(CYCLE), .REP(REP), .SEGMENT(SEGMENT),
    .IDX(IDX), .STOP(STOP), .PENDING(PENDING), .TRANSITION_PULSE(TRANSITION_PULSE));

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: a pending request plus a few integers describing the sequencer
  int          cyc_a[NS];
  int          rep_a[NS];
  int          m_seg, m_idx, m_rep, m_tgt;
  bit          m_stop, m_pend, m_pulse, m_ext, m_seen;
  logic [7:0]  m_mode;
  logic [63:0] m_val;

  task automatic model_reset();
    m_seg = 0; m_idx = 0; m_rep = 0; m_tgt = 0;
    m_stop = 0; m_pend = 0; m_pulse = 0; m_ext = 0; m_seen = 0;
    m_mode = 0; m_val = 0;
  endtask

  task automatic set_cfg();
    for (int k = 0; k < NS; k++) begin
      CYCLE[k*IW +: IW] = cyc_a[k][IW-1:0];
      REP[k*RW +: RW]   = rep_a[k][RW-1:0];
    end
  endtask

  task automatic model_step();
    bit at_end, hit, go, finite;
    int nseg;
    finite = (rep_a[m_seg] != INF);
    at_end = UPDATE && (m_idx >= cyc_a[m_seg]);
    hit    = m_pend && GPIO_IN[m_val[1:0]];
    go     = 0;
    nseg   = m_tgt;
    if (m_pend) begin
      if (m_mode == 8'h00) go = at_end || (UPDATE && m_stop);
      if (m_mode == 8'h01) go = UPDATE && (SYS_TIME >= m_val);
      if (m_mode == 8'h02) go = UPDATE && (m_seen || hit);
      if (m_mode == 8'hFF) go = UPDATE;
    end
    if (!go && m_ext && !m_stop && at_end && finite && m_rep == rep_a[m_seg]) begin
      go = 1;
      nseg = (m_seg + 1) % NS;
    end
    if (hit) m_seen = 1;
    m_pulse = go;
    if (go) begin
      m_seg = nseg; m_idx = 0; m_rep = 0; m_stop = 0; m_pend = 0; m_seen = 0;
    end else if (UPDATE && !m_stop) begin
      if (!at_end) m_idx++;
      else if (!finite) m_idx = 0;
      else if (m_rep == rep_a[m_seg]) m_stop = 1;
      else begin m_rep++; m_idx = 0; end
    end
    if (REQ_VALID && (TRANSITION_MODE inside {8'h00, 8'h01, 8'h02, 8'hF0, 8'hFF})) begin
      m_seen = 0;
      if (TRANSITION_MODE == 8'hF0) begin
        m_ext = 1; m_pend = 0;
      end else begin
        m_ext = 0; m_pend = 1; m_tgt = REQ_SEGMENT;
        m_mode = TRANSITION_MODE; m_val = TRANSITION_VALUE;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".seg"},   SEGMENT, m_seg);
    chk({tag, ".idx"},   IDX, m_idx);
    chk({tag, ".stop"},  STOP, m_stop);
    chk({tag, ".pend"},  PENDING, m_pend);
    chk({tag, ".pulse"}, TRANSITION_PULSE, m_pulse);
  endtask

  task automatic step(input string tag, input bit u, input bit r = 0, input int s = 0,
                      input logic [7:0] md = 0, input logic [63:0] v = 0, input logic [3:0] g = 0);
    UPDATE = u; REQ_VALID = r; REQ_SEGMENT = s[1:0];
    TRANSITION_MODE = md; TRANSITION_VALUE = v; GPIO_IN = g;
    @(posedge CLK);
    model_step();
    #1;
    check_model(tag);
    UPDATE = 0; REQ_VALID = 0; GPIO_IN = 0;
  endtask

  task automatic do_reset();
    RST_N = 0;
    @(posedge CLK);
    #1;
    model_reset();
    check_model("reset");
    RST_N = 1;
  endtask

  int exp_idx[10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};

  initial begin
    logic [7:0] modes[6] = '{8'h00, 8'h01, 8'h02, 8'hF0, 8'hFF, 8'h05};
    int         pick;
    logic [63:0] v;
    model_reset();

    // free-running infinite segment
    cyc_a = '{3, 3, 3, 3}; rep_a = '{INF, INF, INF, INF}; set_cfg();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step("inf", 1);
      chk("inf.idx_seq", IDX, exp_idx[i]);
    end
    chk("inf.nostop", STOP, 0);

    // finite repetitions run out, then SYNC_IDX restarts on seg2
    cyc_a = '{1, 3, 2, 3}; rep_a = '{1, INF, INF, INF}; set_cfg();
    do_reset();
    for (int i = 0; i < 6; i++) step("fin", 1);
    chk("fin.stop", STOP, 1);
    chk("fin.hold", IDX, 1);
    step("fin.req", 0, 1, 2, 8'h00);
    step("fin.sw", 1);
    chk("fin.pulse", TRANSITION_PULSE, 1);
    chk("fin.seg2", SEGMENT, 2);
    step("fin.after", 1);
    chk("fin.pulse_once", TRANSITION_PULSE, 0);

    // SYNC_IDX waits for the wrap tick
    cyc_a = '{3, 3, 3, 3}; rep_a = '{INF, INF, INF, INF}; set_cfg();
    do_reset();
    step("sync", 1);
    step("sync.req", 0, 1, 1, 8'h00);
    chk("sync.pend", PENDING, 1);
    step("sync", 1);
    step("sync", 1);
    chk("sync.idx3", IDX, 3);
    step("sync.sw", 1);
    chk("sync.seg1", SEGMENT, 1);
    chk("sync.idx0", IDX, 0);

    // SYS_TIME threshold, then GPIO sticky
    do_reset();
    SYS_TIME = 64'd990;
    step("st.req", 0, 1, 3, 8'h01, 64'd1000);
    SYS_TIME = 64'd999;
    step("st.999", 1);
    chk("st.no_sw", SEGMENT, 0);
    SYS_TIME = 64'd1000;
    step("st.1000", 1);
    chk("st.sw", SEGMENT, 3);
    step("gp.req", 0, 1, 1, 8'h02, 64'd2);
    step("gp.pulse", 0, 0, 0, 8'h00, 64'd0, 4'b0100);
    step("gp.idle", 0);
    chk("gp.wait", PENDING, 1);
    step("gp.sw", 1);
    chk("gp.seg1", SEGMENT, 1);

    // EXT auto-advance
    cyc_a = '{1, 1, 1, 1}; rep_a = '{0, 0, 0, 0}; set_cfg();
    do_reset();
    step("ext.req", 0, 1, 3, 8'hF0);
    chk("ext.nopend", PENDING, 0);
    for (int i = 0; i < 8; i++) begin
      step("ext", 1);
      if (i == 1) chk("ext.seg1", SEGMENT, 1);
    end
    chk("ext.wrap0", SEGMENT, 0);
    chk("ext.nostop", STOP, 0);

    // last-wins, unknown mode, reset mid-WAIT
    cyc_a = '{2, 2, 2, 2}; rep_a = '{INF, INF, INF, INF}; set_cfg();
    do_reset();
    step("lw.req1", 0, 1, 1, 8'h00);
    step("lw.req2", 0, 1, 3, 8'h00);
    step("lw", 1);
    step("lw", 1);
    step("lw.sw", 1);
    chk("lw.seg3", SEGMENT, 3);
    step("unk", 0, 1, 2, 8'h05);
    chk("unk.pend", PENDING, 0);
    step("mw.req", 1, 1, 1, 8'h00);
    step("mw", 1);
    #2 RST_N = 0;
    #1;
    chk("mw.seg", SEGMENT, 0);
    chk("mw.idx", IDX, 0);
    chk("mw.pend", PENDING, 0);
    chk("mw.stop", STOP, 0);
    chk("mw.pulse", TRANSITION_PULSE, 0);
    model_reset();
    @(negedge CLK);
    RST_N = 1;

    // random traffic
    for (int k = 0; k < NS; k++) begin
      cyc_a[k] = $urandom_range(0, 5);
      rep_a[k] = ($urandom_range(0, 3) == 3) ? INF : $urandom_range(0, 2);
    end
    set_cfg();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        for (int k = 0; k < NS; k++) begin
          cyc_a[k] = $urandom_range(0, 5);
          rep_a[k] = ($urandom_range(0, 3) == 3) ? INF : $urandom_range(0, 2);
        end
        set_cfg();
      end
      SYS_TIME = SYS_TIME + 64'd1;
      pick = $urandom_range(0, 5);
      v = (modes[pick] == 8'h01) ? SYS_TIME + 64'($urandom_range(0, 30)) : 64'($urandom);
      step("rnd", $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3),
           modes[pick], v, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
